poly_mod_fold: RTL and testbench

Streaming negacyclic reduction stage that sits directly downstream of the tile polynomial multiplier. It consumes the 2·DEGREE_N-coefficient product stream, lowest index first, and folds it modulo X^DEGREE_N + 1. It emits DEGREE_N reduced coefficients, out[i] = in[i] − in[i+DEGREE_N], to the relinearization/ciphertext FIFOs. Coefficient arithmetic wraps modulo 2^BIT_WIDTH (two's complement).

---
 rtl/poly_mod_fold.sv | 132 +++++++++++++
 tb/tb_poly_mod_fold.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_mod_fold.sv
// poly_mod_fold
//   Streaming negacyclic fold modulo X^DEGREE_N + 1. Takes the 2*DEGREE_N
//   coefficient product stream (index 0 first) and emits DEGREE_N reduced
//   coefficients out[i] = in[i] - in[i+DEGREE_N], wrapping modulo 2^BIT_WIDTH.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   FILL  | capturing in[0..DEGREE_N-1] into the low buffer; output untouched
//   FOLD  | subtracting in[DEGREE_N..2*DEGREE_N-1] from the buffer, one
//         | result per accepted beat into the single-entry output register
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   valid_i  : coeff_i beat valid
//   coeff_i  : product coefficient
//   ready_o  : beat accepted when valid_i && ready_o
//   valid_o  : coeff_o holds a reduced coefficient
//   coeff_o  : reduced coefficient
//   last_o   : qualifies the final reduced coefficient of a polynomial
//   yumi_i   : downstream consumes coeff_o (only while valid_o is high)

module poly_mod_fold #(
   parameter int DEGREE_N  = 16,
   parameter int BIT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   input  logic [BIT_WIDTH-1:0] coeff_i,
   output logic                 ready_o,
   output logic                 valid_o,
   output logic [BIT_WIDTH-1:0] coeff_o,
   output logic                 last_o,
   input  logic                 yumi_i
);

   localparam int CW = $clog2(2 * DEGREE_N);
   localparam int IW = $clog2(DEGREE_N);

   localparam logic [CW-1:0] CNT_FILL_END = CW'(DEGREE_N - 1);
   localparam logic [CW-1:0] CNT_FOLD_END = CW'(2 * DEGREE_N - 1);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FOLD = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic [BIT_WIDTH-1:0]   coeff_q, coeff_d;
   logic [BIT_WIDTH-1:0]   low_q [DEGREE_N];
   logic                   low_we;
   logic                   accept;

   // DEGREE_N is a power of two, so the low IW bits of cnt address the
   // buffer both while filling (cnt) and while folding (cnt - DEGREE_N).
   logic [IW-1:0]          low_idx;
   assign low_idx = cnt_q[IW-1:0];

   always_comb begin
      ready_o = (state_q == ST_FILL) || !valid_q || yumi_i;
      accept  = valid_i && ready_o;

      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      last_d  = last_q;
      coeff_d = coeff_q;
      low_we  = 1'b0;

      if (yumi_i) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      if (accept) begin
         // cnt is exactly wide enough for 2*DEGREE_N, so the last FOLD beat
         // wraps it to 0 naturally.
         cnt_d = cnt_q + CW'(1);
         unique case (state_q)
            ST_FILL: begin
               low_we = 1'b1;
               if (cnt_q == CNT_FILL_END) begin
                  state_d = ST_FOLD;
               end
            end
            ST_FOLD: begin
               // A new load replaces any value being consumed this cycle.
               coeff_d = low_q[low_idx] - coeff_i;
               valid_d = 1'b1;
               last_d  = (cnt_q == CNT_FOLD_END);
               if (cnt_q == CNT_FOLD_END) begin
                  state_d = ST_FILL;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         coeff_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         coeff_q <= coeff_d;
      end
   end

   // Buffer is fully rewritten each polynomial before it is read, so it
   // carries no reset.
   always_ff @(posedge clk) begin
      if (low_we) begin
         low_q[low_idx] <= coeff_i;
      end
   end

   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign coeff_o = coeff_q;

endmodule

// File: tb/tb_poly_mod_fold.sv
module tb_poly_mod_fold;

   localparam int N = 16;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          valid_i = 1'b0;
   logic [W-1:0]  coeff_i = '0;
   logic          ready_o;
   logic          valid_o;
   logic [W-1:0]  coeff_o;
   logic          last_o;
   logic          yumi_i = 1'b0;
   logic          yumi_en = 1'b1;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [W:0]    exp_q [$];
   logic [W:0]    exp_e;

   poly_mod_fold #(.DEGREE_N(N), .BIT_WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .coeff_i (coeff_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .coeff_o (coeff_o),
      .last_o  (last_o),
      .yumi_i  (yumi_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // ones x (m) product stream
   function automatic logic [W-1:0] prod(input int m, input int k);
      if (k < N)              return W'(m * (k + 1));
      else if (k < 2 * N - 1) return W'(m * (2 * N - 1 - k));
      else                    return '0;
   endfunction

   // hand-derived folded result: m=2 -> 4i+4-32, m=3 -> 6i+6-48
   function automatic logic [W-1:0] exp_out(input int m, input int i);
      return W'(2 * m * i + 2 * m - 16 * m);
   endfunction

   task automatic push_poly(input int m);
      for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), exp_out(m, i)});
   endtask

   // called at posedge+2; returns at posedge+2 of the accepting edge
   task automatic send_beat(input logic [W-1:0] v, input int gap);
      int guard;
      guard = 0;
      valid_i = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #2;
      end
      valid_i = 1'b1;
      coeff_i = v;
      @(negedge clk);
      while (!ready_o && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: ready_o stuck at %b, required 1", ready_o);
      end
      @(posedge clk);
      #2;
      valid_i = 1'b0;
   endtask

   // yumi only when valid_o is up
   initial forever begin
      @(posedge clk);
      #1;
      yumi_i = valid_o && yumi_en;
   end

   // scoreboard monitor
   initial forever begin
      @(negedge clk);
      if (!rst && valid_o && yumi_i) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h, required no output", coeff_o);
         end else begin
            exp_e = exp_q.pop_front();
            check("out_coeff", coeff_o, exp_e[W-1:0]);
            check("out_last", W'(last_o), W'(exp_e[W]));
         end
      end
   end

   initial begin
      int g;
      #1 rst = 1'b1;
      #2;
      check("rst_valid", W'(valid_o), '0);
      check("rst_last", W'(last_o), '0);
      check("rst_coeff", coeff_o, '0);
      check("rst_ready", W'(ready_o), W'(1));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;

      // known product, one cycle latency per output
      push_poly(2);
      for (int k = 0; k < 2 * N; k++) begin
         send_beat(prod(2, k), 0);
         if (k == N - 1) check("fill_no_output", W'(valid_o), '0);
         if (k >= N) begin
            check("lat_valid", W'(valid_o), W'(1));
            check("lat_coeff", coeff_o, exp_out(2, k - N));
         end
      end

      // wrap arithmetic: 0 - 1
      exp_q.push_back({1'b0, 32'hFFFF_FFFF});
      for (int i = 1; i < N - 1; i++) exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b1, 32'h0});
      for (int k = 0; k < 2 * N; k++) send_beat((k == N) ? W'(1) : W'(0), 0);

      // back-pressure
      push_poly(2);
      for (int k = 0; k < 20; k++) send_beat(prod(2, k), 0);
      yumi_en = 1'b0;
      fork
         begin
            for (int k = 20; k < 2 * N; k++) send_beat(prod(2, k), 0);
         end
         begin
            @(posedge clk);
            #3;
            repeat (5) begin
               check("bp_ready", W'(ready_o), '0);
               check("bp_valid", W'(valid_o), W'(1));
               check("bp_coeff", coeff_o, exp_out(2, 4));
               @(posedge clk);
               #3;
            end
            yumi_en = 1'b1;
         end
      join

      // back-to-back, last output of first polynomial held during next FILL
      push_poly(2);
      push_poly(3);
      for (int k = 0; k < 2 * N - 1; k++) send_beat(prod(2, k), 0);
      yumi_en = 1'b0;
      send_beat(prod(2, 2 * N - 1), 0);
      fork
         begin
            for (int k = 0; k < 2 * N; k++) send_beat(prod(3, k), 0);
         end
         begin
            @(posedge clk);
            #3;
            check("b2b_pend_valid", W'(valid_o), W'(1));
            check("b2b_pend_last", W'(last_o), W'(1));
            check("b2b_pend_coeff", coeff_o, exp_out(2, N - 1));
            check("b2b_fill_ready", W'(ready_o), W'(1));
            yumi_en = 1'b1;
         end
      join

      // bubbles
      push_poly(2);
      for (int k = 0; k < 2 * N; k++) send_beat(prod(2, k), $urandom_range(0, 2));

      // reset mid-FOLD after 20 beats
      push_poly(3);
      for (int k = 0; k < 20; k++) send_beat(prod(3, k), 0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", W'(valid_o), '0);
      check("mid_rst_last", W'(last_o), '0);
      check("mid_rst_coeff", coeff_o, '0);
      check("mid_rst_ready", W'(ready_o), W'(1));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #2;
      push_poly(2);
      for (int k = 0; k < 2 * N; k++) send_beat(prod(2, k), 0);

      g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(posedge clk);
         g++;
      end
      check("drain_left", W'(exp_q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
